// File: rtl/bomberman_pkg.sv
// Shared types and constants for the bomb scheduler slice.
// Holds the screen/tile geometry, slot record, FSM states and tile helpers.
package bomberman_pkg;

  localparam int TILE_SIZE = 32;
  localparam int GRID_W    = 25;
  localparam int GRID_H    = 17;
  localparam int SCREEN_W  = 800;
  localparam int SCREEN_H  = 544;

  typedef struct packed {
    logic       valid;
    logic       owner;
    logic [4:0] tx;
    logic [4:0] ty;
    logic [7:0] fuse;
  } bomb_slot_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TICK,
    S_PLACE_A,
    S_PLACE_B
  } sched_state_e;

  // Nearest tile: (pos + TILE_SIZE/2) / TILE_SIZE.
  // Only meaningful for on-screen positions.
  function automatic logic [4:0] to_tile(
    input logic signed [10:0] p
  );
    logic [11:0] s;
    s = {p[10], p} + 12'd16;
    return s[9:5];
  endfunction

  function automatic logic in_screen(
    input logic signed [10:0] x,
    input logic signed [10:0] y
  );
    return !x[10] && (x[9:0] < 10'(SCREEN_W))
        && !y[10] && (y[9:0] < 10'(SCREEN_H));
  endfunction

endpackage

// File: rtl/bomb_free_finder.sv
// Find-first-free encoder over the slot valid bits.
// Ports: valid_i (slot live bits) -> found_o, idx_o (lowest free slot).
module bomb_free_finder #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  valid_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        found_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/bomb_scheduler.sv
// Shared bomb-slot pool: per-EOF fuse ticking, expiry reports and
// round-robin drop arbitration for two players, plus a slot read port.
// Ports: clk, reset (sync, active-high), EOF, j1/j2_bomb keys,
//   player1X/Y, player2X/Y (signed px), rd_idx -> rd_valid/tx/ty/fuse,
//   j1/j2_grant, j1/j2_reject, explode_valid/tx/ty/owner, bombs_p1/p2.
// Option: BOMB_DUP_CHECK_EN rejects drops onto a tile already holding a bomb.
import bomberman_pkg::*;

module bomb_scheduler #(
  parameter int NSLOTS         = 8,
  parameter int MAX_PER_PLAYER = 3,
  parameter int FUSE_FRAMES    = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               EOF,
  input  logic               j1_bomb,
  input  logic               j2_bomb,
  input  logic signed [10:0] player1X,
  input  logic signed [10:0] player1Y,
  input  logic signed [10:0] player2X,
  input  logic signed [10:0] player2Y,
  input  logic [3:0]         rd_idx,
  output logic               rd_valid,
  output logic [4:0]         rd_tx,
  output logic [4:0]         rd_ty,
  output logic [7:0]         rd_fuse,
  output logic               j1_grant,
  output logic               j2_grant,
  output logic               j1_reject,
  output logic               j2_reject,
  output logic               explode_valid,
  output logic [4:0]         explode_tx,
  output logic [4:0]         explode_ty,
  output logic               explode_owner,
  output logic [2:0]         bombs_p1,
  output logic [2:0]         bombs_p2
);

  localparam int IW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

  bomb_slot_t   slots_q [NSLOTS];
  sched_state_e state_q;
  logic [3:0]   idx_q;
  logic [2:0]   cnt_q [2];
  logic [1:0]   key_q, pend_q, pend_d, rise;
  logic         rr_q, both_q;

  logic [NSLOTS-1:0] live;
  logic              found;
  logic [IW-1:0]     free_idx;
  logic              placing, cur_p, in_rng, dup, ok;
  logic signed [10:0] cur_x, cur_y;
  logic [4:0]        cur_tx, cur_ty;

  always_comb begin
    live = '0;
    for (int i = 0; i < NSLOTS; i++) live[i] = slots_q[i].valid;
  end

  bomb_free_finder #(.N(NSLOTS), .IW(IW)) u_free (
    .valid_i (live),
    .found_o (found),
    .idx_o   (free_idx)
  );

  assign placing = (state_q == S_PLACE_A) || (state_q == S_PLACE_B);
  // PLACE_A serves rr_q, PLACE_B the other player.
  assign cur_p  = (state_q == S_PLACE_B) ? ~rr_q : rr_q;
  assign cur_x  = cur_p ? player2X : player1X;
  assign cur_y  = cur_p ? player2Y : player1Y;
  assign cur_tx = to_tile(cur_x);
  assign cur_ty = to_tile(cur_y);
  assign in_rng = in_screen(cur_x, cur_y);

`ifdef BOMB_DUP_CHECK_EN
  logic [NSLOTS-1:0] hit;
  always_comb begin
    hit = '0;
    for (int i = 0; i < NSLOTS; i++)
      hit[i] = slots_q[i].valid
            && (slots_q[i].tx == cur_tx)
            && (slots_q[i].ty == cur_ty);
  end
  assign dup = |hit;
`else
  assign dup = 1'b0;
`endif

  assign ok = (cnt_q[cur_p] < 3'(MAX_PER_PLAYER))
           && found && in_rng && !dup;

  assign rise = {j2_bomb, j1_bomb} & ~key_q;

  // A new edge in the same cycle as the clear survives to the next pass.
  always_comb begin
    pend_d = pend_q;
    if (placing) pend_d[cur_p] = 1'b0;
    pend_d = pend_d | rise;
  end

  assign bombs_p1 = cnt_q[0];
  assign bombs_p2 = cnt_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      for (int i = 0; i < NSLOTS; i++) slots_q[i] <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      key_q    <= '0;
      pend_q   <= '0;
      rr_q     <= 1'b0;
      both_q   <= 1'b0;
      rd_valid <= 1'b0;
      rd_tx    <= '0;
      rd_ty    <= '0;
      rd_fuse  <= '0;
      j1_grant  <= 1'b0;
      j2_grant  <= 1'b0;
      j1_reject <= 1'b0;
      j2_reject <= 1'b0;
      explode_valid <= 1'b0;
      explode_tx    <= '0;
      explode_ty    <= '0;
      explode_owner <= 1'b0;
    end else begin
      j1_grant  <= 1'b0;
      j2_grant  <= 1'b0;
      j1_reject <= 1'b0;
      j2_reject <= 1'b0;
      explode_valid <= 1'b0;
      key_q  <= {j2_bomb, j1_bomb};
      pend_q <= pend_d;

      rd_valid <= 1'b0;
      rd_tx    <= '0;
      rd_ty    <= '0;
      rd_fuse  <= '0;
      for (int i = 0; i < NSLOTS; i++) begin
        if (rd_idx == 4'(i)) begin
          rd_valid <= slots_q[i].valid;
          rd_tx    <= slots_q[i].tx;
          rd_ty    <= slots_q[i].ty;
          rd_fuse  <= slots_q[i].fuse;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (EOF) begin
            state_q <= S_TICK;
            idx_q   <= '0;
          end
        end
        S_TICK: begin
          for (int i = 0; i < NSLOTS; i++) begin
            if (idx_q == 4'(i) && slots_q[i].valid) begin
              if (slots_q[i].fuse == 8'd1) begin
                slots_q[i] <= '0;
                cnt_q[slots_q[i].owner] <=
                  cnt_q[slots_q[i].owner] - 3'd1;
                explode_valid <= 1'b1;
                explode_tx    <= slots_q[i].tx;
                explode_ty    <= slots_q[i].ty;
                explode_owner <= slots_q[i].owner;
              end else begin
                slots_q[i].fuse <= slots_q[i].fuse - 8'd1;
              end
            end
          end
          if (idx_q == 4'(NSLOTS - 1)) state_q <= S_PLACE_A;
          else idx_q <= idx_q + 4'd1;
        end
        S_PLACE_A, S_PLACE_B: begin
          if (pend_q[cur_p]) begin
            if (ok) begin
              for (int i = 0; i < NSLOTS; i++) begin
                if (free_idx == IW'(i)) begin
                  slots_q[i].valid <= 1'b1;
                  slots_q[i].owner <= cur_p;
                  slots_q[i].tx    <= cur_tx;
                  slots_q[i].ty    <= cur_ty;
                  slots_q[i].fuse  <= 8'(FUSE_FRAMES);
                end
              end
              cnt_q[cur_p] <= cnt_q[cur_p] + 3'd1;
              j1_grant <= ~cur_p;
              j2_grant <= cur_p;
            end else begin
              j1_reject <= ~cur_p;
              j2_reject <= cur_p;
            end
          end
          if (state_q == S_PLACE_A) begin
            both_q  <= &pend_q;
            state_q <= S_PLACE_B;
          end else begin
            if (both_q) rr_q <= ~rr_q;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
